scard_rx_buffer: RTL and testbench
==================================

Name: scard_rx_buffer

Overview:
- Byte buffer directly downstream of the smartcard async receiver.
- Captures each received byte on the receiver's one-cycle data-ready strobe and stores it in a circular FIFO.
- Tracks packet boundaries from the receiver's end-of-packet pulse and exposes bytes, fill level and packet status to the host register interface.

Parameters:
- ADDR_W, 4: FIFO address width; depth = 2^ADDR_W bytes.
- CNT_W, 8: width of the packet-length counters; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, same clock as the receiver.
- reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only while rx_data_ready=1.
- rx_data_ready  in  1  one-cycle strobe, byte valid.
- rx_endofpacket  in  1  one-cycle strobe, line gap detected after a burst.
- rx_idle  in  1  receiver idle level.
- clear  in  1  synchronous flush of FIFO, counters and flags.
- rd_en  in  1  host pops one byte.
- dout  out  8  popped byte.
- dout_valid  out  1  one-cycle strobe, dout updated.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- fill  out  ADDR_W+1  bytes currently stored.
- pkt_len  out  CNT_W  bytes received in the current, unterminated packet.
- last_pkt_len  out  CNT_W  length of the most recently completed packet.
- pkt_done  out  1  sticky: a packet completed since the last clear.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- idle  out  1  registered copy of rx_idle.

Behaviour:
- Reset (reset_n=0, asynchronous): pointers=0; fill=0; empty=1; full=0; dout=0x00; dout_valid=0; pkt_len=0; last_pkt_len=0; pkt_done=0; overflow=0; idle=0.
- Write: on clk with rx_data_ready=1.
  - Not full: the byte is stored at wr_ptr, wr_ptr+1 (wraps at 2^ADDR_W), fill+1.
  - Full: the byte is discarded, overflow<=1, pointers unchanged.
- Read: on clk with rd_en=1.
  - Not empty: dout<=mem[rd_ptr], rd_ptr+1 (wraps), fill-1, dout_valid=1 in the following cycle. Read latency is 1 clock.
  - Empty: ignored; dout holds its value, dout_valid=0.
- Simultaneous write and read:
  - Neither empty nor full: both occur, fill unchanged.
  - Empty: only the write occurs; no read-through. Byte is available to rd_en next cycle.
  - Full: the read frees one slot and the write is accepted in the same cycle, no overflow. fill stays 2^ADDR_W.
- Status flags: full = (fill==2^ADDR_W); empty = (fill==0). Both derive from registered fill, no combinational path from inputs.
- Packet tracking:
  - Every accepted or dropped byte increments pkt_len, saturating at 2^CNT_W-1.
  - rx_endofpacket=1 with pkt_len>0: last_pkt_len<=pkt_len, pkt_done<=1, pkt_len<=0.
  - rx_endofpacket=1 with pkt_len==0: ignored.
  - rx_data_ready and rx_endofpacket in the same cycle (not produced by the receiver, but defined): the byte is counted into the closing packet, i.e. last_pkt_len<=pkt_len+1.
- clear=1 (synchronous, priority over all other activity in that cycle):
  - pointers, fill, pkt_len, last_pkt_len, pkt_done and overflow return to reset values.
  - A concurrent rx_data_ready byte is lost.
  - dout is unchanged.
- idle <= rx_idle, registered every cycle.
- Asserting reset_n mid-packet discards all buffered data; the next rx_data_ready starts a new packet.

Optional Feature:
- Macro: SCARD_RXBUF_INVCONV_EN. Adds ISO 7816 inverse-convention decode at the FIFO input.
- Defined:
  - After reset or clear, the first byte written is the TS byte. If it equals 0x03 (TS 0x3F seen under direct decode), inverse mode is latched.
  - In inverse mode, every byte including TS is stored as the bitwise inverse of its bit-reversed value, so TS is stored as 0x3F.
  - Any other TS value (e.g. 0x3B) leaves direct mode latched; bytes are stored unchanged.
  - The latched mode persists until reset or clear.
  - Extra output port: inv_conv out 1 (reset 0), set when inverse mode is latched.
- Not defined: bytes are stored unchanged and port inv_conv is absent.

Test Plan:
- Reset, then 3 strobes of 0x3B, 0x95, 0x11, then rx_endofpacket -> fill=3, last_pkt_len=3, pkt_done=1, pkt_len=0. Three rd_en pulses return 0x3B, 0x95, 0x11, each with dout_valid one cycle after its rd_en; then empty=1.
- ADDR_W=4: write 17 bytes 0x00..0x10 -> full=1 after 16 bytes, overflow=1, pkt_len=17. Reads return 0x00..0x0F.
- With FIFO full, rd_en and rx_data_ready=0xAA in the same cycle -> overflow stays 0, fill=16, and 0xAA is the last byte read out.
- With FIFO empty, rd_en and a write of 0x55 in the same cycle -> dout_valid=0 next cycle, fill=1. A following rd_en returns 0x55.
- Mid-packet clear with fill=5, pkt_len=5, overflow=1 -> all counters and flags 0, empty=1, dout unchanged. rx_endofpacket immediately after leaves pkt_done=0.
- SCARD_RXBUF_INVCONV_EN defined: write 0x03, then 0x80 -> inv_conv=1; stored bytes read back as 0x3F, 0xFE. Repeat after clear with TS 0x3B -> inv_conv=0; bytes read back unchanged.

Source files
------------

// File: rtl/scard_rx_buffer.sv
// Circular byte FIFO behind the smartcard receiver, with packet-length tracking and status flags; 1-cycle read latency.
// No backpressure to the receiver: bytes arriving while full are dropped and flagged. Optional SCARD_RXBUF_INVCONV_EN adds inverse-convention decode.
module scard_rx_buffer #(
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_ready,
    input  logic              rx_endofpacket,
    input  logic              rx_idle,
    input  logic              clear,
    input  logic              rd_en,
    output logic [7:0]        dout,
    output logic              dout_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   fill,
    output logic [CNT_W-1:0]  pkt_len,
    output logic [CNT_W-1:0]  last_pkt_len,
    output logic              pkt_done,
    output logic              overflow,
    output logic              idle
`ifdef SCARD_RXBUF_INVCONV_EN
    ,
    output logic              inv_conv
`endif
);

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_F = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_go;
    logic              rd_go;
    logic              drop;
    logic [7:0]        wr_byte;
    logic [CNT_W-1:0]  pkt_len_inc;
    logic [CNT_W-1:0]  closing_len;

    assign full  = (fill == DEPTH_F);
    assign empty = (fill == '0);

    // A read on a full FIFO frees the slot the concurrent write lands in.
    assign rd_go = rd_en && !empty;
    assign wr_go = rx_data_ready && (!full || rd_en);
    assign drop  = rx_data_ready && full && !rd_en;

    assign pkt_len_inc = (pkt_len == CNT_MAX) ? pkt_len : pkt_len + CNT_W'(1);
    assign closing_len = rx_data_ready ? pkt_len_inc : pkt_len;

`ifdef SCARD_RXBUF_INVCONV_EN
    logic       ts_seen;
    logic       ts_is_inv;
    logic [7:0] rx_rev;

    always_comb begin
        rx_rev = '0;
        for (int i = 0; i < 8; i++) begin
            rx_rev[i] = rx_data[7-i];
        end
    end

    // 0x03 is how an inverse-convention TS (0x3F) looks through direct decode.
    assign ts_is_inv = !ts_seen && (rx_data == 8'h03);
    assign wr_byte   = (inv_conv || ts_is_inv) ? ~rx_rev : rx_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts_seen  <= 1'b0;
            inv_conv <= 1'b0;
        end else if (clear) begin
            ts_seen  <= 1'b0;
            inv_conv <= 1'b0;
        end else if (wr_go && !ts_seen) begin
            ts_seen  <= 1'b1;
            inv_conv <= ts_is_inv;
        end
    end
`else
    assign wr_byte = rx_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_go && !clear) begin
            mem[wr_ptr] <= wr_byte;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            dout         <= 8'h00;
            dout_valid   <= 1'b0;
            pkt_len      <= '0;
            last_pkt_len <= '0;
            pkt_done     <= 1'b0;
            overflow     <= 1'b0;
            idle         <= 1'b0;
        end else begin
            idle <= rx_idle;
            if (clear) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                fill         <= '0;
                dout_valid   <= 1'b0;
                pkt_len      <= '0;
                last_pkt_len <= '0;
                pkt_done     <= 1'b0;
                overflow     <= 1'b0;
            end else begin
                dout_valid <= rd_go;
                if (wr_go) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (rd_go) begin
                    dout   <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                case ({wr_go, rd_go})
                    2'b10:   fill <= fill + (ADDR_W + 1)'(1);
                    2'b01:   fill <= fill - (ADDR_W + 1)'(1);
                    default: fill <= fill;
                endcase
                if (drop) begin
                    overflow <= 1'b1;
                end
                // A byte arriving with the end-of-packet pulse belongs to the closing packet.
                if (rx_endofpacket && (closing_len != '0)) begin
                    last_pkt_len <= closing_len;
                    pkt_done     <= 1'b1;
                    pkt_len      <= '0;
                end else if (rx_data_ready) begin
                    pkt_len <= pkt_len_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_scard_rx_buffer.sv
// Directed bench for scard_rx_buffer: expected bytes queued at write time, compared when read out.
module tb_scard_rx_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic        rx_endofpacket;
    logic        rx_idle;
    logic        clear;
    logic        rd_en;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        empty;
    logic        full;
    logic [4:0]  fill;
    logic [7:0]  pkt_len;
    logic [7:0]  last_pkt_len;
    logic        pkt_done;
    logic        overflow;
    logic        idle;
`ifdef SCARD_RXBUF_INVCONV_EN
    logic        inv_conv;
`endif

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  sb[$];

    scard_rx_buffer #(.ADDR_W(4), .CNT_W(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_data_ready(rx_data_ready),
        .rx_endofpacket(rx_endofpacket),
        .rx_idle(rx_idle),
        .clear(clear),
        .rd_en(rd_en),
        .dout(dout),
        .dout_valid(dout_valid),
        .empty(empty),
        .full(full),
        .fill(fill),
        .pkt_len(pkt_len),
        .last_pkt_len(last_pkt_len),
        .pkt_done(pkt_done),
        .overflow(overflow),
        .idle(idle)
`ifdef SCARD_RXBUF_INVCONV_EN
        ,
        .inv_conv(inv_conv)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit expect_stored);
        rx_data       = b;
        rx_data_ready = 1'b1;
        tick();
        rx_data_ready = 1'b0;
        if (expect_stored) sb.push_back(b);
    endtask

    task automatic rd_chk(input string tag);
        logic [7:0] exp;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk({tag, "_valid"}, dout_valid, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_underrun"}, 1, 0);
        end else begin
            exp = sb.pop_front();
            chk({tag, "_dout"}, dout, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sb.delete();
    endtask

    task automatic eop();
        rx_endofpacket = 1'b1;
        tick();
        rx_endofpacket = 1'b0;
    endtask

    initial begin
        reset_n        = 1'b0;
        rx_data        = 8'h00;
        rx_data_ready  = 1'b0;
        rx_endofpacket = 1'b0;
        rx_idle        = 1'b1;
        clear          = 1'b0;
        rd_en          = 1'b0;
        #12;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_fill", fill, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_pkt_len", pkt_len, 0);
        chk("rst_last_pkt_len", last_pkt_len, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_idle", idle, 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("idle_follow", idle, 1);
        rx_idle = 1'b0;
        tick();
        chk("idle_follow0", idle, 0);

        // Basic packet of three bytes
        wr(8'h3B, 1); wr(8'h95, 1); wr(8'h11, 1);
        chk("p1_pkt_len_open", pkt_len, 3);
        eop();
        chk("p1_fill", fill, 3);
        chk("p1_last_pkt_len", last_pkt_len, 3);
        chk("p1_pkt_done", pkt_done, 1);
        chk("p1_pkt_len", pkt_len, 0);
        rd_chk("p1_rd0"); rd_chk("p1_rd1"); rd_chk("p1_rd2");
        chk("p1_empty", empty, 1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        chk("rd_empty_valid", dout_valid, 0);
        chk("rd_empty_hold", dout, 8'h11);

        // Byte coinciding with end-of-packet joins the closing packet; bare eop with pkt_len 0 is ignored
        do_clear();
        wr(8'h01, 1); wr(8'h02, 1);
        rx_data = 8'h07; rx_data_ready = 1'b1; rx_endofpacket = 1'b1;
        tick();
        rx_data_ready = 1'b0; rx_endofpacket = 1'b0;
        sb.push_back(8'h07);
        chk("eopb_last", last_pkt_len, 3);
        chk("eopb_pkt_len", pkt_len, 0);
        chk("eopb_fill", fill, 3);
        eop();
        chk("eop0_last", last_pkt_len, 3);
        rd_chk("eopb_rd0"); rd_chk("eopb_rd1"); rd_chk("eopb_rd2");

        // Full FIFO with simultaneous read and write
        do_clear();
        for (int i = 0; i < 16; i++) wr(8'(i), 1);
        chk("full_flag", full, 1);
        chk("full_fill", fill, 16);
        chk("full_ovf0", overflow, 0);
        rd_en = 1'b1; rx_data = 8'hAA; rx_data_ready = 1'b1;
        tick();
        rd_en = 1'b0; rx_data_ready = 1'b0;
        chk("fsim_valid", dout_valid, 1);
        chk("fsim_dout", dout, sb.pop_front());
        sb.push_back(8'hAA);
        chk("fsim_ovf", overflow, 0);
        chk("fsim_fill", fill, 16);
        for (int i = 0; i < 16; i++) rd_chk("fsim_drain");
        chk("fsim_empty", empty, 1);

        // Overflow: 17th byte dropped but still counted
        do_clear();
        for (int i = 0; i < 17; i++) wr(8'(i), i < 16);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_pkt_len", pkt_len, 17);
        eop();
        chk("ovf_last", last_pkt_len, 17);
        for (int i = 0; i < 16; i++) rd_chk("ovf_drain");
        chk("ovf_empty", empty, 1);
        chk("ovf_sticky", overflow, 1);

        // Mid-packet clear with a concurrent byte
        for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i), 1);
        chk("mc_fill", fill, 5);
        chk("mc_pkt_len", pkt_len, 5);
        clear = 1'b1; rx_data = 8'h99; rx_data_ready = 1'b1;
        tick();
        clear = 1'b0; rx_data_ready = 1'b0;
        sb.delete();
        chk("mc_fill0", fill, 0);
        chk("mc_empty", empty, 1);
        chk("mc_pkt_len0", pkt_len, 0);
        chk("mc_last0", last_pkt_len, 0);
        chk("mc_done0", pkt_done, 0);
        chk("mc_ovf0", overflow, 0);
        chk("mc_dout_hold", dout, 8'h0F);
        eop();
        chk("mc_eop_done", pkt_done, 0);

        // Empty FIFO: simultaneous read and write, no read-through
        rd_en = 1'b1; rx_data = 8'h55; rx_data_ready = 1'b1;
        tick();
        rd_en = 1'b0; rx_data_ready = 1'b0;
        sb.push_back(8'h55);
        chk("esim_valid", dout_valid, 0);
        chk("esim_fill", fill, 1);
        rd_chk("esim_rd");

        // Packet length saturation
        do_clear();
        for (int i = 0; i < 260; i++) wr(8'(i), i < 16);
        chk("sat_pkt_len", pkt_len, 255);
        eop();
        chk("sat_last", last_pkt_len, 255);
        rd_chk("sat_rd0");

`ifdef SCARD_RXBUF_INVCONV_EN
        do_clear();
        wr(8'h03, 0); sb.push_back(8'h3F);
        wr(8'h80, 0); sb.push_back(8'hFE);
        chk("inv_flag", inv_conv, 1);
        rd_chk("inv_rd0"); rd_chk("inv_rd1");
        do_clear();
        chk("inv_clr", inv_conv, 0);
        wr(8'h3B, 1); wr(8'h80, 1);
        chk("dir_flag", inv_conv, 0);
        rd_chk("dir_rd0"); rd_chk("dir_rd1");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
